// File: rtl/xstat.sv
// xstat: status-register exchange with optional privilege check, 1-cycle latency.
// Build option: define XSTAT_TRAP_CHECK_EN to fault exec requests made outside trap mode.
module xstat #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic [WIDTH-1:0] status_register,
    input  logic             trap_mode,
    input  logic [WIDTH-1:0] current_register,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] status_out,
    output logic             status_we,
    output logic             done,
    output logic             fault
);

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_status_out;
    logic             r_status_we;
    logic             r_done;
    logic             r_fault;
    logic             w_priv_ok;

`ifdef XSTAT_TRAP_CHECK_EN
    assign w_priv_ok = trap_mode;
`else
    // trap_mode is still read so the port stays connected; it cannot block the exchange
    assign w_priv_ok = trap_mode | 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result     <= '0;
            r_status_out <= '0;
            r_status_we  <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_status_we <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            if (exec) begin
                r_done <= 1'b1;
                if (w_priv_ok) begin
                    r_result     <= status_register;
                    r_status_out <= current_register;
                    r_status_we  <= 1'b1;
                end else begin
                    // register is written back with its own value; status is left alone
                    r_result <= current_register;
                    r_fault  <= 1'b1;
                end
            end
        end
    end

    assign result     = r_result;
    assign status_out = r_status_out;
    assign status_we  = r_status_we;
    assign done       = r_done;
    assign fault      = r_fault;

endmodule

// File: tb/tb_xstat.sv
// Directed testbench for xstat: expected outputs queued at drive time, popped after each edge.
module tb_xstat;

    localparam int WIDTH = 20;
`ifdef XSTAT_TRAP_CHECK_EN
    localparam bit TRAP_CHECK = 1'b1;
`else
    localparam bit TRAP_CHECK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             exec = 1'b0;
    logic [WIDTH-1:0] status_register = '0;
    logic             trap_mode = 1'b0;
    logic [WIDTH-1:0] current_register = '0;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] status_out;
    logic             status_we;
    logic             done;
    logic             fault;

    xstat #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .exec             (exec),
        .status_register  (status_register),
        .trap_mode        (trap_mode),
        .current_register (current_register),
        .result           (result),
        .status_out       (status_out),
        .status_we        (status_we),
        .done             (done),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] status_out;
        logic             status_we;
        logic             done;
        logic             fault;
    } exp_t;

    exp_t             sb_q[$];
    int               n_pass = 0;
    int               n_total = 0;
    logic [WIDTH-1:0] m_result = '0;
    logic [WIDTH-1:0] m_status = '0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic check_all(input exp_t e);
        check({e.tag, ".result"},     result,     e.result);
        check({e.tag, ".status_out"}, status_out, e.status_out);
        check({e.tag, ".status_we"},  {19'd0, status_we}, {19'd0, e.status_we});
        check({e.tag, ".done"},       {19'd0, done},      {19'd0, e.done});
        check({e.tag, ".fault"},      {19'd0, fault},     {19'd0, e.fault});
    endtask

    // Drive one cycle of stimulus at the falling edge, queue the expectation, check after the rising edge.
    task automatic step(input string tag, input logic ex, input logic [WIDTH-1:0] st,
                        input logic tm, input logic [WIDTH-1:0] rg);
        exp_t e;
        @(negedge clk);
        exec = ex;
        status_register = st;
        trap_mode = tm;
        current_register = rg;
        e.tag = tag;
        e.status_we = 1'b0;
        e.done = 1'b0;
        e.fault = 1'b0;
        if (ex) begin
            e.done = 1'b1;
            if (TRAP_CHECK && !tm) begin
                m_result = rg;
                e.fault = 1'b1;
            end else begin
                m_result = st;
                m_status = rg;
                e.status_we = 1'b1;
            end
        end
        e.result = m_result;
        e.status_out = m_status;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard: got empty queue, want one entry");
        end else begin
            check_all(sb_q.pop_front());
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t e;
        e.tag = tag;
        e.result = '0;
        e.status_out = '0;
        e.status_we = 1'b0;
        e.done = 1'b0;
        e.fault = 1'b0;
        check_all(e);
    endtask

    initial begin
        // Asynchronous reset before the first rising edge at t=5.
        #1 rst = 1'b1;
        #1 check_zero("reset_async");
        @(negedge clk);
        rst = 1'b0;

        step("fault",      1'b1, 20'h12345, 1'b0, 20'hABCDE);
        step("exchange",   1'b1, 20'h00000, 1'b1, 20'hABCDE);
        step("hold",       1'b0, 20'hFFFFF, 1'b1, 20'hFFFFF);
        step("hold_trap",  1'b0, 20'hFFFFF, 1'b0, 20'hFFFFF);
        step("b2b_first",  1'b1, 20'h00001, 1'b1, 20'hFFFFF);
        step("b2b_second", 1'b1, 20'hFFFFF, 1'b1, 20'h00002);
        step("b2b_idle",   1'b0, 20'h00000, 1'b1, 20'h00000);
        step("equal_vals", 1'b1, 20'h5A5A5, 1'b1, 20'h5A5A5);
        step("fault_b2b",  1'b1, 20'h0F0F0, 1'b0, 20'hF0F0F);
        step("xchg_after", 1'b1, 20'h13579, 1'b1, 20'h2468A);
        for (int i = 0; i < 8; i++) begin
            step("random", 1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)),
                 20'($urandom));
        end
        step("pre_reset",  1'b1, 20'h11111, 1'b1, 20'h22222);

        // Reset asserted in the same cycle as exec cancels the operation.
        @(negedge clk);
        exec = 1'b1;
        trap_mode = 1'b1;
        status_register = 20'h33333;
        current_register = 20'h44444;
        rst = 1'b1;
        #1 check_zero("reset_mid_async");
        @(posedge clk);
        #1 check_zero("reset_mid_edge");
        @(negedge clk);
        exec = 1'b0;
        rst = 1'b0;
        m_result = '0;
        m_status = '0;
        step("post_reset", 1'b0, 20'h55555, 1'b1, 20'h66666);
        step("post_xchg",  1'b1, 20'h77777, 1'b1, 20'h88888);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
